// File: rtl/usb_crc_engine.sv
// usb_crc_engine
//   Serial CRC generator/checker for the USB TX and RX paths; one instance per CRC type.
//   Data bits are absorbed LSB-first into the CRC register. On request, the complemented CRC
//   is shifted out MSB-first with a per-bit advance handshake from the bit stuffer. A good
//   residual in the register is flagged for RX packet checking.
//
// Ports
//   clk          system clock
//   n_rst        synchronous active-low reset
//   clear        synchronous re-init, overrides everything but reset
//   bit_in       data bit, absorbed when new_bit=1
//   new_bit      absorb strobe (ignored while sending)
//   crc_calc     level request to send the CRC, held until crc_send falls
//   bit_advance  bit stuffer consumed the current serial_out bit
//   crc_send     high while CRC bits are on serial_out
//   crc_done     one-cycle pulse after the last CRC bit is consumed
//   serial_out   data pass-through, CRC bit stream, or idle 1 after the CRC
//   crc_ok       crc register equals the good-packet residual
//   crc_value    current CRC register, uncomplemented

module usb_crc_engine #(
    parameter int unsigned                 CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0]        POLY      = CRC_WIDTH'(16'h8005),
    parameter logic [CRC_WIDTH-1:0]        INIT      = '1,
    parameter logic [CRC_WIDTH-1:0]        RESIDUAL  = CRC_WIDTH'(16'h800D)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 bit_in,
    input  logic                 new_bit,
    input  logic                 crc_calc,
    input  logic                 bit_advance,
    output logic                 crc_send,
    output logic                 crc_done,
    output logic                 serial_out,
    output logic                 crc_ok,
    output logic [CRC_WIDTH-1:0] crc_value
);

    localparam int unsigned CntW = $clog2(CRC_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {StAccum, StSend, StDone} state_e;

    state_e                 state_q;
    logic [CRC_WIDTH-1:0]   crc_q;
    logic [CRC_WIDTH-1:0]   sreg_q;
    logic [CntW-1:0]        count_q;
    logic [CRC_WIDTH-1:0]   crc_next;
    logic                   fb;

    // Next CRC value including a bit absorbed this cycle; also used when the
    // final data bit arrives together with crc_calc.
    always_comb begin
        fb       = bit_in ^ crc_q[CRC_WIDTH-1];
        crc_next = crc_q;
        if (new_bit) begin
            crc_next = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= StAccum;
            crc_q    <= INIT;
            sreg_q   <= '0;
            count_q  <= '0;
            crc_send <= 1'b0;
            crc_done <= 1'b0;
        end else if (clear) begin
            // Drops any pending CRC bits and any bit strobed this cycle.
            state_q  <= StAccum;
            crc_q    <= INIT;
            sreg_q   <= '0;
            count_q  <= '0;
            crc_send <= 1'b0;
            crc_done <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            unique case (state_q)
                StAccum: begin
                    crc_q <= crc_next;
                    if (crc_calc) begin
                        state_q  <= StSend;
                        sreg_q   <= ~crc_next;
                        count_q  <= '0;
                        crc_send <= 1'b1;
                    end
                end
                StSend: begin
                    // crc_calc dropping here is illegal and deliberately ignored.
                    if (bit_advance) begin
                        sreg_q <= {sreg_q[CRC_WIDTH-2:0], 1'b0};
                        if (count_q == LastCnt) begin
                            state_q  <= StDone;
                            count_q  <= '0;
                            crc_send <= 1'b0;
                            crc_done <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (!crc_calc) begin
                        state_q <= StAccum;
                        crc_q   <= INIT;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    always_comb begin
        serial_out = bit_in;
        unique case (state_q)
            StAccum: serial_out = bit_in;
            StSend:  serial_out = sreg_q[CRC_WIDTH-1];
            StDone:  serial_out = 1'b1;
            default: serial_out = bit_in;
        endcase
    end

    assign crc_ok    = (crc_q == RESIDUAL);
    assign crc_value = crc_q;

endmodule

// File: tb/tb_usb_crc_engine.sv
module tb_usb_crc_engine;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic n_rst, clear, bit_in, new_bit, crc_calc, bit_advance;
    logic use16;

    // Only the selected instance sees strobes, so the idle one never desyncs.
    logic nb5, cc5, ba5, nb16, cc16, ba16;
    assign nb5  = new_bit & ~use16;
    assign cc5  = crc_calc & ~use16;
    assign ba5  = bit_advance & ~use16;
    assign nb16 = new_bit & use16;
    assign cc16 = crc_calc & use16;
    assign ba16 = bit_advance & use16;

    logic        c5_send, c5_done, c5_so, c5_ok;
    logic [4:0]  c5_val;
    logic        c16_send, c16_done, c16_so, c16_ok;
    logic [15:0] c16_val;

    usb_crc_engine #(
        .CRC_WIDTH (5),
        .POLY      (5'h05),
        .INIT      (5'h1F),
        .RESIDUAL  (5'h0C)
    ) u_crc5 (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .bit_in      (bit_in),
        .new_bit     (nb5),
        .crc_calc    (cc5),
        .bit_advance (ba5),
        .crc_send    (c5_send),
        .crc_done    (c5_done),
        .serial_out  (c5_so),
        .crc_ok      (c5_ok),
        .crc_value   (c5_val)
    );

    usb_crc_engine #(
        .CRC_WIDTH (16),
        .POLY      (16'h8005),
        .INIT      (16'hFFFF),
        .RESIDUAL  (16'h800D)
    ) u_crc16 (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .bit_in      (bit_in),
        .new_bit     (nb16),
        .crc_calc    (cc16),
        .bit_advance (ba16),
        .crc_send    (c16_send),
        .crc_done    (c16_done),
        .serial_out  (c16_so),
        .crc_ok      (c16_ok),
        .crc_value   (c16_val)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic get_so();
        return use16 ? c16_so : c5_so;
    endfunction

    function automatic logic get_send();
        return use16 ? c16_send : c5_send;
    endfunction

    function automatic logic get_done();
        return use16 ? c16_done : c5_done;
    endfunction

    function automatic logic [15:0] get_val();
        return use16 ? c16_val : {11'd0, c5_val};
    endfunction

    function automatic logic get_ok();
        return use16 ? c16_ok : c5_ok;
    endfunction

    function automatic int width_of(input logic sel16);
        return sel16 ? 16 : 5;
    endfunction

    // Polynomial division of the message (bit 0 first) with an all-ones preset.
    function automatic int model_crc(input int w, input logic [63:0] msg, input int len);
        int poly = (w == 5) ? 'h05 : 'h8005;
        int mask = (1 << w) - 1;
        int r    = mask;
        for (int i = 0; i < len; i++) begin
            int top = (r >> (w - 1)) & 1;
            r = (r << 1) & mask;
            if ((top ^ int'(msg[i])) != 0) r = r ^ poly;
        end
        return r;
    endfunction

    task automatic do_reset();
        n_rst = 1'b0; clear = 1'b0; bit_in = 1'b0; new_bit = 1'b0;
        crc_calc = 1'b0; bit_advance = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    // Feeds len bits, with random idle cycles and stray bit_advance in between.
    task automatic feed_msg(input logic [63:0] msg, input int len);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                new_bit = 1'b0; bit_in = 1'($urandom); bit_advance = 1'($urandom);
                tick();
            end
            bit_in = msg[i]; new_bit = 1'b1; bit_advance = 1'($urandom);
            tick();
        end
        new_bit = 1'b0; bit_advance = 1'b0;
    endtask

    // Runs one CRC send with `gap` stall cycles before each advance and collects the stream.
    task automatic send_crc(input int w, input int gap, input bit started,
                            output logic [15:0] stream, output int hold_bad,
                            output int done_cnt, output int done_bad,
                            output logic [15:0] val_in_done);
        logic first;
        stream = '0; hold_bad = 0; done_cnt = 0; done_bad = 0;
        if (!started) begin
            crc_calc = 1'b1;
            tick();
        end
        crc_calc = 1'b1;
        for (int i = 0; i < w; i++) begin
            settle();
            first = get_so();
            for (int g = 0; g < gap; g++) begin
                if (get_send() !== 1'b1 || get_so() !== first) hold_bad++;
                new_bit = 1'($urandom); bit_in = 1'($urandom);
                tick();
                settle();
            end
            if (get_send() !== 1'b1 || get_so() !== first) hold_bad++;
            stream = {stream[14:0], first};
            bit_advance = 1'b1; new_bit = 1'($urandom);
            tick();
            bit_advance = 1'b0;
        end
        new_bit = 1'b0;
        settle();
        if (get_done() === 1'b1) done_cnt++;
        if (get_send() !== 1'b0 || get_so() !== 1'b1) done_bad++;
        val_in_done = get_val();
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            if (get_done() === 1'b1) done_cnt++;
            if (get_send() !== 1'b0 || get_so() !== 1'b1) done_bad++;
        end
        crc_calc = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        use16 = 1'b0;
        do_reset();
        bit_in = 1'b1;
        settle();
        n_cmp++;
        if (c5_send !== 1'b0 || c5_done !== 1'b0 || c5_val !== 5'h1F || c5_ok !== 1'b0
            || c5_so !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_crc5: send=%b done=%b val=%h ok=%b so=%b, want 0 0 1f 0 1",
                     c5_send, c5_done, c5_val, c5_ok, c5_so);
        end
        bit_in = 1'b0;
        settle();
        n_cmp++;
        if (c16_send !== 1'b0 || c16_done !== 1'b0 || c16_val !== 16'hFFFF || c16_ok !== 1'b0
            || c16_so !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_crc16: send=%b done=%b val=%h ok=%b so=%b, want 0 0 ffff 0 0",
                     c16_send, c16_done, c16_val, c16_ok, c16_so);
        end
    endtask

    // Known-answer CRC5 sends: empty message, single 1, single 0.
    task automatic test_crc5_known();
        logic [15:0] stream, vd;
        int hb, dc, db;
        logic [4:0] exp_val [3] = '{5'h1F, 5'b11110, 5'b11011};
        logic [4:0] exp_str [3] = '{5'b00000, 5'b00001, 5'b00100};
        use16 = 1'b0;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            if (t > 0) begin
                bit_in = (t == 1); new_bit = 1'b1;
                tick();
                new_bit = 1'b0;
            end
            settle();
            n_cmp++;
            if (c5_val !== exp_val[t]) begin
                n_bad++;
                $display("FAIL crc5_known_val[%0d]: got %b want %b", t, c5_val, exp_val[t]);
            end
            send_crc(5, 0, 1'b0, stream, hb, dc, db, vd);
            n_cmp++;
            if (stream[4:0] !== exp_str[t] || hb != 0 || dc != 1 || db != 0) begin
                n_bad++;
                $display("FAIL crc5_known_send[%0d]: stream=%b hold=%0d done=%0d dbad=%0d, want %b 0 1 0",
                         t, stream[4:0], hb, dc, db, exp_str[t]);
            end
            settle();
            n_cmp++;
            if (c5_val !== 5'h1F || c5_send !== 1'b0) begin
                n_bad++;
                $display("FAIL crc5_known_reinit[%0d]: val=%h send=%b want 1f 0", t, c5_val, c5_send);
            end
        end
    endtask

    // 1,0,0,0,0,1 lands on the residual; any single flipped bit must not.
    task automatic test_crc5_rx();
        logic [63:0] msg;
        use16 = 1'b0;
        do_reset();
        msg = 64'b100001;
        feed_msg(msg, 6);
        settle();
        n_cmp++;
        if (c5_val !== 5'h0C || c5_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL crc5_rx_good: val=%h ok=%b want 0c 1", c5_val, c5_ok);
        end
        for (int i = 0; i < 6; i++) begin
            clear = 1'b1; tick(); clear = 1'b0;
            feed_msg(msg ^ (64'd1 << i), 6);
            settle();
            n_cmp++;
            if (c5_ok !== 1'b0) begin
                n_bad++;
                $display("FAIL crc5_rx_flip[%0d]: ok=%b val=%h want ok 0", i, c5_ok, c5_val);
            end
        end
    endtask

    // Random data followed by its own complemented CRC must hit the residual.
    task automatic test_random_rx();
        logic [63:0] msg, full;
        int w, len, c, flip;
        for (int t = 0; t < 8; t++) begin
            use16 = 1'($urandom);
            w = width_of(use16);
            len = $urandom_range(1, 40);
            msg = {$urandom, $urandom};
            c = model_crc(w, msg, len);
            full = msg;
            for (int j = 0; j < w; j++) full[len + j] = ~c[w - 1 - j];
            clear = 1'b1; tick(); clear = 1'b0;
            feed_msg(full, len + w);
            settle();
            n_cmp++;
            if (get_ok() !== 1'b1 || get_val() !== (use16 ? 16'h800D : 16'h000C)) begin
                n_bad++;
                $display("FAIL random_rx_good[%0d] w=%0d len=%0d: ok=%b val=%h", t, w, len,
                         get_ok(), get_val());
            end
            flip = $urandom_range(0, len + w - 1);
            clear = 1'b1; tick(); clear = 1'b0;
            feed_msg(full ^ (64'd1 << flip), len + w);
            settle();
            n_cmp++;
            if (get_ok() !== 1'b0) begin
                n_bad++;
                $display("FAIL random_rx_flip[%0d] w=%0d bit=%0d: ok=%b want 0", t, w, flip, get_ok());
            end
        end
    endtask

    // Consecutive packets without reset, random widths, stalls, and last bit with crc_calc.
    task automatic test_back_to_back();
        logic [63:0] msg;
        logic [15:0] stream, vd, exp_s;
        int w, len, exp, hb, dc, db, gap;
        bit with_calc;
        do_reset();
        for (int t = 0; t < 12; t++) begin
            use16 = 1'($urandom);
            w = width_of(use16);
            len = $urandom_range(1, 40);
            msg = {$urandom, $urandom};
            with_calc = 1'($urandom);
            gap = $urandom_range(0, 2);
            exp = model_crc(w, msg, len);
            exp_s = 16'(~exp & ((1 << w) - 1));
            feed_msg(msg, with_calc ? len - 1 : len);
            if (with_calc) begin
                bit_in = msg[len - 1]; new_bit = 1'b1; crc_calc = 1'b1;
                tick();
                new_bit = 1'b0;
            end
            send_crc(w, gap, with_calc, stream, hb, dc, db, vd);
            n_cmp++;
            if (vd !== 16'(exp) || (stream & 16'((1 << w) - 1)) !== exp_s) begin
                n_bad++;
                $display("FAIL b2b_crc[%0d] w=%0d len=%0d: val=%h stream=%h want %h %h",
                         t, w, len, vd, stream, 16'(exp), exp_s);
            end
            n_cmp++;
            if (hb != 0 || dc != 1 || db != 0) begin
                n_bad++;
                $display("FAIL b2b_handshake[%0d]: hold=%0d done=%0d dbad=%0d want 0 1 0",
                         t, hb, dc, db);
            end
        end
    endtask

    // CRC16 with an advance every third cycle: 16 zero bits, each held until advanced.
    task automatic test_crc16_stall();
        logic [15:0] stream, vd;
        int hb, dc, db;
        use16 = 1'b1;
        do_reset();
        send_crc(16, 2, 1'b0, stream, hb, dc, db, vd);
        n_cmp++;
        if (stream !== 16'h0000 || hb != 0 || dc != 1 || db != 0 || vd !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL crc16_stall: stream=%h hold=%0d done=%0d dbad=%0d val=%h want 0000 0 1 0 ffff",
                     stream, hb, dc, db, vd);
        end
    endtask

    task automatic test_clear_mid_send();
        int done_seen;
        use16 = 1'b1;
        do_reset();
        feed_msg({$urandom, $urandom}, 8);
        crc_calc = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bit_advance = 1'b1;
            tick();
        end
        bit_advance = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0; crc_calc = 1'b0; bit_in = 1'b1;
        settle();
        n_cmp++;
        if (c16_send !== 1'b0 || c16_val !== 16'hFFFF || c16_done !== 1'b0 || c16_so !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_mid_send: send=%b val=%h done=%b so=%b want 0 ffff 0 1",
                     c16_send, c16_val, c16_done, c16_so);
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            bit_advance = 1'($urandom);
            tick();
            if (c16_done === 1'b1) done_seen++;
        end
        bit_advance = 1'b0;
        n_cmp++;
        if (done_seen != 0 || c16_val !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL clear_no_done: pulses=%0d val=%h want 0 ffff", done_seen, c16_val);
        end
        // A bit strobed alongside clear must be dropped.
        clear = 1'b1; new_bit = 1'b1; bit_in = 1'b1;
        tick();
        clear = 1'b0; new_bit = 1'b0;
        settle();
        n_cmp++;
        if (c16_val !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL clear_drops_bit: val=%h want ffff", c16_val);
        end
    endtask

    task automatic test_reset_mid_send();
        use16 = 1'b1;
        do_reset();
        feed_msg({$urandom, $urandom}, 5);
        crc_calc = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bit_advance = 1'b1;
            tick();
        end
        bit_advance = 1'b0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1; crc_calc = 1'b0; bit_in = 1'b0;
        settle();
        n_cmp++;
        if (c16_send !== 1'b0 || c16_done !== 1'b0 || c16_val !== 16'hFFFF || c16_ok !== 1'b0
            || c16_so !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_send: send=%b done=%b val=%h ok=%b so=%b want 0 0 ffff 0 0",
                     c16_send, c16_done, c16_val, c16_ok, c16_so);
        end
    endtask

    initial begin
        use16 = 1'b0;
        test_reset();
        test_crc5_known();
        test_crc5_rx();
        test_random_rx();
        test_back_to_back();
        test_crc16_stall();
        test_clear_mid_send();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
